call_stack_ctrl: RTL and testbench

// Sequencer and arbiter in front of the hardware call stack (push/pop storage, ADDR_W-bit entries).
// Two requesters share the stack: the core (CALL/RET) and the interrupt unit (ENTER/EXIT).
// The block serialises their requests, drives the stack's execute/mode/data_in and captures return addresses.
// It tracks depth, rejects overflow/underflow, and keeps sticky error flags for the debug/status path.

---
 rtl/call_stack_ctrl.sv | 139 +++++++++++++
 tb/tb_call_stack_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/call_stack_ctrl.sv
// Call-stack sequencer: arbitrates core CALL/RET and irq ENTER/EXIT onto one
// push/pop stack, tracks depth and keeps sticky overflow/underflow flags.
module call_stack_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 16,
    parameter int DEPTH_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic               core_req,
    input  logic               core_op,
    input  logic [ADDR_W-1:0]  core_addr,
    output logic               core_ack,
    output logic               core_err,
    input  logic               irq_req,
    input  logic               irq_op,
    input  logic [ADDR_W-1:0]  irq_addr,
    output logic               irq_ack,
    output logic               irq_err,
    output logic               ret_valid,
    output logic [ADDR_W-1:0]  ret_addr,
    output logic               cs_execute,
    output logic               cs_mode,
    output logic [ADDR_W-1:0]  cs_data_in,
    input  logic [ADDR_W-1:0]  cs_data_out,
    output logic [DEPTH_W:0]   depth,
    output logic               full,
    output logic               empty,
    output logic               ovf_sticky,
    output logic               unf_sticky,
    input  logic               clr_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP,
        S_RDATA,
        S_REJECT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_owner_irq;
    logic                r_is_push;
    logic [ADDR_W-1:0]   r_data;
    logic [DEPTH_W:0]    r_depth;
    logic [ADDR_W-1:0]   r_ret;
    logic                r_ovf;
    logic                r_unf;

    logic                w_req;
    logic                w_is_push;
    logic [ADDR_W-1:0]   w_pdata;
    logic                w_full;
    logic                w_empty;
    logic                w_done;

    assign w_full  = (r_depth == (DEPTH_W+1)'(DEPTH));
    assign w_empty = (r_depth == '0);

    // irq has fixed priority over the core
    assign w_req     = irq_req | core_req;
    assign w_is_push = irq_req ? ~irq_op : ~core_op;
    assign w_pdata   = irq_req ? irq_addr : core_addr + ADDR_W'(1);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if ((w_is_push && w_full) || (!w_is_push && w_empty))
                        w_next = S_REJECT;
                    else if (w_is_push)
                        w_next = S_PUSH;
                    else
                        w_next = S_POP;
                end
            end
            S_PUSH:   w_next = S_IDLE;
            S_POP:    w_next = S_RDATA;
            S_RDATA:  w_next = S_IDLE;
            S_REJECT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner_irq <= 1'b0;
            r_is_push   <= 1'b0;
            r_data      <= '0;
            r_depth     <= '0;
            r_ret       <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else if (clk_en) begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_req) begin
                r_owner_irq <= irq_req;
                r_is_push   <= w_is_push;
                r_data      <= w_pdata;
            end
            if (r_state == S_PUSH)
                r_depth <= r_depth + 1'b1;
            else if (r_state == S_POP)
                r_depth <= r_depth - 1'b1;
            if (r_state == S_RDATA)
                r_ret <= cs_data_out;
            // a reject in the same cycle beats clr_err
            r_ovf <= (r_ovf & ~clr_err) |
                     (r_state == S_REJECT && r_is_push);
            r_unf <= (r_unf & ~clr_err) |
                     (r_state == S_REJECT && !r_is_push);
        end
    end

    assign w_done = clk_en && (r_state == S_PUSH ||
                               r_state == S_RDATA ||
                               r_state == S_REJECT);

    assign core_ack   = w_done && !r_owner_irq;
    assign irq_ack    = w_done && r_owner_irq;
    assign core_err   = clk_en && r_state == S_REJECT && !r_owner_irq;
    assign irq_err    = clk_en && r_state == S_REJECT && r_owner_irq;
    assign ret_valid  = clk_en && r_state == S_RDATA;
    assign cs_execute = clk_en && (r_state == S_PUSH || r_state == S_POP);
    assign cs_mode    = (r_state == S_POP);
    assign cs_data_in = (r_state == S_PUSH) ? r_data : '0;
    assign ret_addr   = r_ret;
    assign depth      = r_depth;
    assign full       = w_full;
    assign empty      = w_empty;
    assign ovf_sticky = r_ovf;
    assign unf_sticky = r_unf;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl with a small behavioural stack attached.
module tb_call_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic       core_req, core_op;
    logic [9:0] core_addr;
    logic       core_ack, core_err;
    logic       irq_req, irq_op;
    logic [9:0] irq_addr;
    logic       irq_ack, irq_err;
    logic       ret_valid;
    logic [9:0] ret_addr;
    logic       cs_execute, cs_mode;
    logic [9:0] cs_data_in;
    logic [9:0] cs_data_out;
    logic [4:0] depth;
    logic       full, empty, ovf_sticky, unf_sticky, clr_err;

    int checks = 0;
    int failures = 0;

    call_stack_ctrl #(.ADDR_W(10), .DEPTH(16), .DEPTH_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .core_req(core_req), .core_op(core_op), .core_addr(core_addr),
        .core_ack(core_ack), .core_err(core_err),
        .irq_req(irq_req), .irq_op(irq_op), .irq_addr(irq_addr),
        .irq_ack(irq_ack), .irq_err(irq_err),
        .ret_valid(ret_valid), .ret_addr(ret_addr),
        .cs_execute(cs_execute), .cs_mode(cs_mode),
        .cs_data_in(cs_data_in), .cs_data_out(cs_data_out),
        .depth(depth), .full(full), .empty(empty),
        .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // behavioural stack: top readable the cycle after a pop strobe
    logic [9:0] mem [16];
    logic [4:0] sp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            cs_data_out <= '0;
        end else if (cs_execute) begin
            if (!cs_mode) begin
                mem[sp[3:0]] <= cs_data_in;
                sp <= sp + 1'b1;
            end else begin
                cs_data_out <= mem[4'(sp - 1'b1)];
                sp <= sp - 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // issue one request and wait for its ack (bounded)
    task automatic do_op(input logic use_irq, input logic op,
                         input logic [9:0] addr, output int lat,
                         output logic err, output logic exec,
                         output logic [9:0] pd, output logic rv);
        bit done = 0;
        lat = 0; err = 0; exec = 0; pd = '0; rv = 0;
        if (use_irq) begin
            irq_req = 1; irq_op = op; irq_addr = addr;
        end else begin
            core_req = 1; core_op = op; core_addr = addr;
        end
        for (int i = 0; i < 10 && !done; i++) begin
            step();
            lat++;
            if (cs_execute) begin
                exec = 1;
                pd = cs_data_in;
            end
            if (ret_valid) rv = 1;
            if (use_irq ? irq_ack : core_ack) begin
                err = use_irq ? irq_err : core_err;
                done = 1;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL ack_timeout got=none exp=ack");
        end
        step();
        irq_req = 0;
        core_req = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; clk_en = 1; clr_err = 0;
        core_req = 0; core_op = 0; core_addr = '0;
        irq_req = 0; irq_op = 0; irq_addr = '0;
        #12;
        rst_n = 1;
        step();
        checks++;
        if ({depth, empty, full, ovf_sticky, unf_sticky} !== 9'b00000_1_0_0_0) begin
            failures++;
            $display("FAIL reset_status got=%b exp=%b",
                     {depth, empty, full, ovf_sticky, unf_sticky}, 9'b000001000);
        end
        checks++;
        if ({cs_execute, core_ack, irq_ack, ret_valid, ret_addr} !== 14'h0) begin
            failures++;
            $display("FAIL reset_strobes got=%h exp=0",
                     {cs_execute, core_ack, irq_ack, ret_valid, ret_addr});
        end
    endtask

    task automatic test_call();
        int lat; logic err, ex, rv; logic [9:0] pd;
        do_op(0, 0, 10'h123, lat, err, ex, pd, rv);
        checks++;
        if ({lat, err, ex, pd} !== {32'd1, 1'b0, 1'b1, 10'h124}) begin
            failures++;
            $display("FAIL call_push got=lat%0d err%b ex%b pd%h exp=lat1 err0 ex1 pd124",
                     lat, err, ex, pd);
        end
        checks++;
        if (depth !== 5'd1) begin
            failures++;
            $display("FAIL call_depth got=%0d exp=1", depth);
        end
    endtask

    task automatic test_wrap();
        int lat; logic err, ex, rv; logic [9:0] pd;
        do_op(0, 0, 10'h3FF, lat, err, ex, pd, rv);
        checks++;
        if (pd !== 10'h000) begin
            failures++;
            $display("FAIL wrap_push got=%h exp=000", pd);
        end
        do_op(0, 1, 10'h0, lat, err, ex, pd, rv);
        checks++;
        if ({lat, err, rv, ret_addr} !== {32'd2, 1'b0, 1'b1, 10'h000}) begin
            failures++;
            $display("FAIL wrap_ret got=lat%0d err%b rv%b ra%h exp=lat2 err0 rv1 ra000",
                     lat, err, rv, ret_addr);
        end
        do_op(0, 1, 10'h0, lat, err, ex, pd, rv);
        checks++;
        if ({ret_addr, depth, empty} !== {10'h124, 5'd0, 1'b1}) begin
            failures++;
            $display("FAIL ret_second got=ra%h d%0d e%b exp=ra124 d0 e1",
                     ret_addr, depth, empty);
        end
    endtask

    task automatic test_overflow();
        int lat; logic err, ex, rv; logic [9:0] pd;
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            do_op(0, 0, 10'(i * 37), lat, err, ex, pd, rv);
            if (err || pd !== 10'(i * 37 + 1)) bad++;
        end
        checks++;
        if (bad !== 0 || full !== 1'b1 || depth !== 5'd16) begin
            failures++;
            $display("FAIL fill16 got=bad%0d full%b d%0d exp=bad0 full1 d16",
                     bad, full, depth);
        end
        do_op(0, 0, 10'h055, lat, err, ex, pd, rv);
        checks++;
        if ({err, ex, ovf_sticky, full, depth} !== {1'b1, 1'b0, 1'b1, 1'b1, 5'd16}) begin
            failures++;
            $display("FAIL ovf_reject got=err%b ex%b ovf%b full%b d%0d exp=1 0 1 1 16",
                     err, ex, ovf_sticky, full, depth);
        end
        bad = 0;
        for (int i = 15; i >= 0; i--) begin
            do_op(0, 1, 10'h0, lat, err, ex, pd, rv);
            if (err || ret_addr !== 10'(i * 37 + 1)) bad++;
        end
        checks++;
        if (bad !== 0 || !empty) begin
            failures++;
            $display("FAIL lifo_drain got=bad%0d empty%b exp=bad0 empty1", bad, empty);
        end
        do_op(0, 1, 10'h0, lat, err, ex, pd, rv);
        checks++;
        if ({err, ex, unf_sticky, depth} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
            failures++;
            $display("FAIL unf_reject got=err%b ex%b unf%b d%0d exp=1 0 1 0",
                     err, ex, unf_sticky, depth);
        end
    endtask

    task automatic test_clr();
        core_req = 1; core_op = 1;
        step();
        checks++;
        if ({core_ack, core_err} !== 2'b11) begin
            failures++;
            $display("FAIL clr_rej_cycle got=%b exp=11", {core_ack, core_err});
        end
        clr_err = 1;
        step();
        core_req = 0; clr_err = 0;
        checks++;
        if ({unf_sticky, ovf_sticky} !== 2'b10) begin
            failures++;
            $display("FAIL clr_vs_set got=unf%b ovf%b exp=unf1 ovf0",
                     unf_sticky, ovf_sticky);
        end
        clr_err = 1;
        step();
        clr_err = 0;
        checks++;
        if (unf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL clr_plain got=%b exp=0", unf_sticky);
        end
    endtask

    task automatic test_arb();
        int lat; logic err, ex, rv; logic [9:0] pd;
        core_req = 1; core_op = 0; core_addr = 10'h055;
        irq_req = 1; irq_op = 0; irq_addr = 10'h200;
        step();
        checks++;
        if ({irq_ack, core_ack, cs_execute, cs_data_in} !== {3'b101, 10'h200}) begin
            failures++;
            $display("FAIL arb_irq_first got=i%b c%b x%b d%h exp=1 0 1 200",
                     irq_ack, core_ack, cs_execute, cs_data_in);
        end
        step();
        irq_req = 0;
        step();
        checks++;
        if ({irq_ack, core_ack, cs_data_in} !== {2'b01, 10'h056}) begin
            failures++;
            $display("FAIL arb_core_next got=i%b c%b d%h exp=0 1 056",
                     irq_ack, core_ack, cs_data_in);
        end
        step();
        core_req = 0;
        do_op(0, 1, 10'h0, lat, err, ex, pd, rv);
        checks++;
        if (ret_addr !== 10'h056) begin
            failures++;
            $display("FAIL arb_lifo_ret got=%h exp=056", ret_addr);
        end
        do_op(1, 1, 10'h0, lat, err, ex, pd, rv);
        checks++;
        if ({ret_addr, depth, err} !== {10'h200, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL arb_lifo_exit got=ra%h d%0d err%b exp=200 0 0",
                     ret_addr, depth, err);
        end
    endtask

    task automatic test_clken_reset();
        int lat; logic err, ex, rv; logic [9:0] pd;
        do_op(0, 0, 10'h0AA, lat, err, ex, pd, rv);
        core_req = 1; core_op = 1;
        step();
        checks++;
        if ({cs_execute, cs_mode} !== 2'b11) begin
            failures++;
            $display("FAIL pop_strobe got=%b exp=11", {cs_execute, cs_mode});
        end
        clk_en = 0;
        #1;
        checks++;
        if (cs_execute !== 1'b0) begin
            failures++;
            $display("FAIL gated_strobe got=%b exp=0", cs_execute);
        end
        step();
        checks++;
        if ({depth, cs_execute, core_ack} !== {5'd1, 2'b00}) begin
            failures++;
            $display("FAIL frozen got=d%0d x%b a%b exp=1 0 0",
                     depth, cs_execute, core_ack);
        end
        clk_en = 1;
        #1;
        checks++;
        if (cs_execute !== 1'b1) begin
            failures++;
            $display("FAIL resume_strobe got=%b exp=1", cs_execute);
        end
        step();
        checks++;
        if ({ret_valid, core_ack, depth} !== {2'b11, 5'd0}) begin
            failures++;
            $display("FAIL rdata_cycle got=rv%b a%b d%0d exp=1 1 0",
                     ret_valid, core_ack, depth);
        end
        rst_n = 0;
        #1;
        core_req = 0;
        checks++;
        if ({ret_valid, core_ack, core_err, cs_execute, ret_addr, depth, empty, full}
            !== {4'b0000, 10'h000, 5'd0, 2'b10}) begin
            failures++;
            $display("FAIL reset_midop got=rv%b a%b x%b ra%h d%0d e%b f%b exp=0 0 0 000 0 1 0",
                     ret_valid, core_ack, cs_execute, ret_addr, depth, empty, full);
        end
        step();
        rst_n = 1;
        step();
        checks++;
        if ({core_ack, irq_ack, cs_execute, ovf_sticky, unf_sticky} !== 5'b0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b exp=00000",
                     {core_ack, irq_ack, cs_execute, ovf_sticky, unf_sticky});
        end
    endtask

    initial begin
        test_reset();
        test_call();
        test_wrap();
        test_overflow();
        test_clr();
        test_arb();
        test_clken_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
